// File: rtl/net_output_stage_if.sv
// net_output_stage_if: sample strobe, packed conv lanes and audio outputs of the output stage.
interface net_output_stage_if #(
  parameter int W     = 16,
  parameter int D     = 8,
  parameter int CNT_W = 8
);
  logic                 sample_clk;
  logic                 in_v;
  logic [D*W-1:0]       packed_in;
  logic signed [W-1:0]  sample_out0;
  logic signed [W-1:0]  sample_out1;
  logic signed [W-1:0]  sample_out2;
  logic signed [W-1:0]  sample_out3;
  logic                 underrun;
  logic [CNT_W-1:0]     underrun_count;
  modport master (
    output sample_clk, in_v, packed_in,
    input  sample_out0, sample_out1, sample_out2, sample_out3, underrun, underrun_count
  );
  modport slave (
    input  sample_clk, in_v, packed_in,
    output sample_out0, sample_out1, sample_out2, sample_out3, underrun, underrun_count
  );
endinterface

// File: rtl/net_output_stage.sv
// net_output_stage: captures the top four conv lanes with saturating gain and plays them out
// on sample ticks, optionally slew-limited, counting ticks that find no fresh result.
module net_output_stage #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int SHIFT    = 2,
  parameter int MAX_STEP = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  net_output_stage_if.slave bus
);
  typedef enum logic {IDLE, PENDING} state_t;
  localparam logic signed [W:0] MS = (W+1)'(MAX_STEP);
  state_t              state_q;
  logic                in_v_q, sclk_q, armed_q, primed_q, underrun_q;
  logic [CNT_W-1:0]    cnt_q;
  logic signed [W-1:0] pend_q [4];
  logic signed [W-1:0] tgt_q  [4];
  logic signed [W-1:0] out_q  [4];
  logic signed [W-1:0] sat_d  [4];
  logic signed [W-1:0] step_d [4];
  logic                cap, tick;
  function automatic logic signed [W-1:0] sat_shl(input logic signed [W-1:0] x);
    logic signed [W+SHIFT-1:0] e;
    logic [SHIFT:0]            top;
    e   = (W+SHIFT)'(x) <<< SHIFT;
    top = e[W+SHIFT-1:W-1];
    return (&top || ~|top) ? e[W-1:0] : (x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
  endfunction
  function automatic logic signed [W-1:0] step(input logic signed [W-1:0] cur, input logic signed [W-1:0] tgt);
    logic signed [W:0] diff;
    diff = {tgt[W-1], tgt} - {cur[W-1], cur};
    diff = diff > MS ? MS : (diff < -MS ? -MS : diff);
    return (MAX_STEP == 0) ? tgt : cur + diff[W-1:0];
  endfunction
  // The first edge after reset only loads the edge detectors, so levels already high stay silent.
  assign cap  = armed_q && bus.in_v && !in_v_q;
  assign tick = armed_q && bus.sample_clk && !sclk_q;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sat_d[i]  = sat_shl(bus.packed_in[(D-1-i)*W +: W]);
      step_d[i] = step(out_q[i], state_q == PENDING ? pend_q[i] : tgt_q[i]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_v_q     <= 1'b0;
      sclk_q     <= 1'b0;
      armed_q    <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= '0;
        tgt_q[i]  <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      in_v_q  <= bus.in_v;
      sclk_q  <= bus.sample_clk;
      armed_q <= 1'b1;
      if (tick && (state_q == PENDING || primed_q)) begin
        for (int i = 0; i < 4; i++) begin
          out_q[i] <= step_d[i];
          if (state_q == PENDING) tgt_q[i] <= pend_q[i];
        end
        if (state_q == IDLE) begin
          underrun_q <= 1'b1;
          if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
      end
      if (cap) begin
        for (int i = 0; i < 4; i++) pend_q[i] <= sat_d[i];
        primed_q <= 1'b1;
        state_q  <= PENDING;
      end else if (tick) begin
        state_q <= IDLE;
      end
    end
  end
  assign bus.sample_out0    = out_q[0];
  assign bus.sample_out1    = out_q[1];
  assign bus.sample_out2    = out_q[2];
  assign bus.sample_out3    = out_q[3];
  assign bus.underrun       = underrun_q;
  assign bus.underrun_count = cnt_q;
endmodule

// File: tb/tb_net_output_stage.sv
// tb_net_output_stage: directed scenarios on a default instance, a CNT_W=2 instance and a
// MAX_STEP=1000 instance, all sharing one stimulus.
module tb_net_output_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk = 1'b0;
  logic         in_v = 1'b0;
  logic [127:0] packed_in = '0;
  int           n_chk = 0;
  int           n_pass = 0;
  always #5 clk = ~clk;
  net_output_stage_if #(.W(16), .D(8), .CNT_W(8)) ia ();
  net_output_stage_if #(.W(16), .D(8), .CNT_W(2)) ib ();
  net_output_stage_if #(.W(16), .D(8), .CNT_W(8)) ic ();
  assign ia.sample_clk = sclk;
  assign ia.in_v       = in_v;
  assign ia.packed_in  = packed_in;
  assign ib.sample_clk = sclk;
  assign ib.in_v       = in_v;
  assign ib.packed_in  = packed_in;
  assign ic.sample_clk = sclk;
  assign ic.in_v       = in_v;
  assign ic.packed_in  = packed_in;
  net_output_stage #(.W(16), .D(8), .SHIFT(2), .MAX_STEP(0), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  net_output_stage #(.W(16), .D(8), .SHIFT(2), .MAX_STEP(0), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  net_output_stage #(.W(16), .D(8), .SHIFT(2), .MAX_STEP(1000), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ic));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic do_reset();
    sclk = 1'b0;
    in_v = 1'b0;
    packed_in = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_cap(input logic [15:0] l7, input logic [15:0] l6, input logic [15:0] l5, input logic [15:0] l4);
    packed_in = {l7, l6, l5, l4, 64'h0};
    in_v = 1'b1;
    @(posedge clk);
    #1 in_v = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_tick();
    sclk = 1'b1;
    @(posedge clk);
    #1 sclk = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset();
    chk("rst_out0", ia.sample_out0, 16'h0000);
    chk("rst_out3", ia.sample_out3, 16'h0000);
    chk("rst_urun", 16'(ia.underrun), 16'h0000);
    chk("rst_cnt", 16'(ia.underrun_count), 16'h0000);
    repeat (3) do_tick();
    chk("unprimed_urun", 16'(ia.underrun), 16'h0000);
    chk("unprimed_cnt", 16'(ia.underrun_count), 16'h0000);
    do_cap(16'h1000, 16'h2000, 16'hE000, 16'h1FFF);
    chk("pend_hold_out0", ia.sample_out0, 16'h0000);
    sclk = 1'b1;
    @(posedge clk);
    #1;
    chk("lat_out0", ia.sample_out0, 16'h4000);
    chk("lat_out1", ia.sample_out1, 16'h7FFF);
    chk("lat_out2", ia.sample_out2, 16'h8000);
    chk("lat_out3", ia.sample_out3, 16'h7FFC);
    sclk = 1'b0;
    @(posedge clk);
    #1;
    chk("load_urun", 16'(ia.underrun), 16'h0000);
    do_tick();
    chk("urun1", 16'(ia.underrun), 16'h0001);
    chk("urun1_cnt", 16'(ia.underrun_count), 16'h0001);
    chk("urun1_hold", ia.sample_out0, 16'h4000);
    do_reset();
    do_cap(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    repeat (5) do_tick();
    chk("sat_cnt_b", 16'(ib.underrun_count), 16'h0003);
    chk("cnt5_a", 16'(ia.underrun_count), 16'h0005);
    do_reset();
    do_cap(16'h0100, 16'hC001, 16'h0000, 16'h0000);
    do_cap(16'h0200, 16'hC001, 16'h0000, 16'h0000);
    do_tick();
    chk("latest_out0", ia.sample_out0, 16'h0800);
    chk("negsat_out1", ia.sample_out1, 16'h8000);
    chk("latest_cnt", 16'(ia.underrun_count), 16'h0000);
    do_reset();
    do_cap(16'h0C00, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 1; i <= 14; i++) begin
      do_tick();
      chk($sformatf("slew_out0_%0d", i), ic.sample_out0, (i <= 12) ? 16'(1000 * i) : 16'd12288);
      chk($sformatf("slew_cnt_%0d", i), 16'(ic.underrun_count), 16'(i - 1));
    end
    chk("direct_out0", ia.sample_out0, 16'h3000);
    do_reset();
    do_cap(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    chk("s6_load", ia.sample_out0, 16'h0400);
    packed_in = {16'h0300, 112'h0};
    sclk = 1'b1;
    in_v = 1'b1;
    @(posedge clk);
    #1;
    chk("both_cnt", 16'(ia.underrun_count), 16'h0001);
    chk("both_hold", ia.sample_out0, 16'h0400);
    sclk = 1'b0;
    in_v = 1'b0;
    @(posedge clk);
    #1;
    do_tick();
    chk("both_next_out0", ia.sample_out0, 16'h0C00);
    chk("both_next_cnt", 16'(ia.underrun_count), 16'h0001);
    do_cap(16'h0700, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_out0", ia.sample_out0, 16'h0000);
    chk("async_cnt", 16'(ia.underrun_count), 16'h0000);
    chk("async_urun", 16'(ia.underrun), 16'h0000);
    in_v = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_tick();
    chk("held_inv_out0", ia.sample_out0, 16'h0000);
    chk("held_inv_cnt", 16'(ia.underrun_count), 16'h0000);
    in_v = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
